// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone memory slave: default bus widths,
// FSM state encoding and the index-width helper.
package wb_pkg;

  localparam int WB_DWIDTH = 32;
  localparam int WB_AWIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } wb_state_e;

  // Smallest n with 2**n >= value; constant-evaluable for parameter math.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_mem_slave_if.sv
// Wishbone classic-cycle bus bundle between a master and wb_mem_slave.
// Signal names are seen from the slave side (_i into the slave, _o out of it).
interface wb_mem_slave_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 16
);

  // A transfer is requested while cyc_i & stb_i are both high; the master
  // holds adr_i/dat_i/we_i stable until ack_o or err_o pulses for one cycle,
  // and dropping cyc_i or stb_i earlier abandons the transfer.
  logic [AWIDTH-1:0] adr_i;
  logic [DWIDTH-1:0] dat_i;
  logic              we_i;
  logic              cyc_i;
  logic              stb_i;
  logic [DWIDTH-1:0] dat_o;
  logic              ack_o;
  logic              err_o;

  modport master (
    output adr_i, dat_i, we_i, cyc_i, stb_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  adr_i, dat_i, we_i, cyc_i, stb_i,
    output dat_o, ack_o, err_o
  );

endinterface

// File: rtl/wb_mem_ram.sv
// Single-port word array: synchronous write, synchronous read with a read
// enable so the read register holds between reads. No reset on contents.
module wb_mem_ram #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16,
  parameter int IW     = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IW-1:0]     idx_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic slave with internal word memory and WAIT_STATES-cycle stall.
// Define WB_MEM_SLAVE_ERR_EN to answer out-of-range addresses with err_o.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int DWIDTH      = WB_DWIDTH,
  parameter int AWIDTH      = WB_AWIDTH,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_mem_slave_if.slave bus,
  output wb_state_e     state_o
);

  localparam int         IW        = (MEM_DEPTH > 1) ? clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              rd_zero_q, rd_zero_d;
  logic              req, oor, commit;
  logic              ram_we, ram_re;
  logic [IW-1:0]     idx;
  logic [DWIDTH-1:0] ram_rdata;

  assign req = bus.cyc_i & bus.stb_i;
  assign idx = bus.adr_i[IW-1:0];

`ifdef WB_MEM_SLAVE_ERR_EN
  assign oor = |(bus.adr_i >> IW);
`else
  assign oor = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The memory access happens on the same edge that enters ACK.
    ack_d     = commit & ~oor;
    err_d     = commit & oor;
    ram_we    = commit & bus.we_i & ~oor;
    ram_re    = commit & ~bus.we_i & ~oor;
    rd_zero_d = rd_zero_q;
    if (commit && !bus.we_i) rd_zero_d = oor;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  wb_mem_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (MEM_DEPTH),
    .IW     (IW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .idx_i   (idx),
    .wdata_i (bus.dat_i),
    .rdata_o (ram_rdata)
  );

  // The RAM read register has no reset, so zero is muxed in after reset and errored reads.
  assign bus.dat_o = rd_zero_q ? '0 : ram_rdata;
  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Bench for wb_mem_slave: a zero-wait and a three-wait instance share clock and
// reset; table vectors, hand sequences and random traffic against a word model.
module tb_wb_mem_slave;
  import wb_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_mem_slave_if #(.DWIDTH(DW), .AWIDTH(AW)) bus0 ();
  wb_mem_slave_if #(.DWIDTH(DW), .AWIDTH(AW)) bus3 ();
  wb_state_e st0, st3;

  wb_mem_slave #(.DWIDTH(DW), .AWIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0), .state_o(st0)
  );
  wb_mem_slave #(.DWIDTH(DW), .AWIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .bus(bus3), .state_o(st3)
  );

  int checks = 0;
  int errors = 0;
  int ws [2] = '{0, 3};

  // Reference: plain word arrays plus the value dat_o should currently show.
  logic [31:0] mem_m   [2][DEPTH];
  logic [31:0] last_rd [2];

  typedef struct {
    int          w;
    bit          we;
    logic [15:0] adr;
    logic [31:0] d;
    logic [31:0] exp_dat;
    bit          exp_err;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input bit cyc, input bit stb, input bit we,
                       input logic [15:0] adr, input logic [31:0] d);
    if (w == 0) begin
      bus0.cyc_i = cyc; bus0.stb_i = stb; bus0.we_i = we; bus0.adr_i = adr; bus0.dat_i = d;
    end else begin
      bus3.cyc_i = cyc; bus3.stb_i = stb; bus3.we_i = we; bus3.adr_i = adr; bus3.dat_i = d;
    end
  endtask

  function automatic logic ack_of(input int w);
    return (w == 0) ? bus0.ack_o : bus3.ack_o;
  endfunction
  function automatic logic err_of(input int w);
    return (w == 0) ? bus0.err_o : bus3.err_o;
  endfunction
  function automatic logic [31:0] dat_of(input int w);
    return (w == 0) ? bus0.dat_o : bus3.dat_o;
  endfunction

  task automatic model_xfer(input int w, input bit we, input logic [15:0] adr,
                            input logic [31:0] d, output bit e_err, output logic [31:0] e_dat);
    bit oor;
    int idx;
    idx = int'(adr) % DEPTH;
`ifdef WB_MEM_SLAVE_ERR_EN
    oor = (int'(adr) >= DEPTH);
`else
    oor = 1'b0;
`endif
    e_err = oor;
    if (we) begin
      if (!oor) mem_m[w][idx] = d;
    end else begin
      last_rd[w] = oor ? 32'h0 : mem_m[w][idx];
    end
    e_dat = last_rd[w];
  endtask

  // Starts just after a rising edge; returns just after a rising edge.
  task automatic xfer(input int w, input bit we, input logic [15:0] adr, input logic [31:0] d,
                      input bit e_err, input logic [31:0] e_dat, input string tag);
    int lat;
    logic got_ack, got_err;
    logic [31:0] got_dat;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; got_dat = 32'h0;
    drive(w, 1'b1, 1'b1, we, adr, d);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack_of(w) || err_of(w)) begin
        lat = n; got_ack = ack_of(w); got_err = err_of(w); got_dat = dat_of(w);
        break;
      end
    end
    drive(w, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    chk({tag, " latency"}, lat, ws[w] + 1);
    chk({tag, " ack"}, {31'b0, got_ack}, {31'b0, !e_err});
    chk({tag, " err"}, {31'b0, got_err}, {31'b0, e_err});
    chk({tag, " dat_o"}, got_dat, e_dat);
    @(posedge clk); #1;
    chk({tag, " single pulse"}, {31'b0, ack_of(w) | err_of(w)}, 32'h0);
  endtask

  task automatic model_and_xfer(input int w, input bit we, input logic [15:0] adr,
                                input logic [31:0] d, input string tag);
    bit e_err;
    logic [31:0] e_dat;
    model_xfer(w, we, adr, d, e_err, e_dat);
    xfer(w, we, adr, d, e_err, e_dat, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          e_err;
    logic [31:0] e_dat;
    int          acks, first_ack, prev_ack, consec;

    vecs[0] = '{0, 1'b1, 16'd3,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{0, 1'b0, 16'd3,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1, 1'b1, 16'd1,  32'h5,        32'h0,        1'b0};
    vecs[3] = '{1, 1'b0, 16'd1,  32'h0,        32'h5,        1'b0};
    vecs[4] = '{1, 1'b1, 16'd2,  32'h0,        32'h5,        1'b0};
    vecs[5] = '{0, 1'b1, 16'd1,  32'h11,       32'hDEADBEEF, 1'b0};
`ifdef WB_MEM_SLAVE_ERR_EN
    vecs[6] = '{0, 1'b1, 16'd17, 32'h77,       32'hDEADBEEF, 1'b1};
    vecs[7] = '{0, 1'b0, 16'd1,  32'h0,        32'h11,       1'b0};
    vecs[8] = '{0, 1'b0, 16'd17, 32'h0,        32'h0,        1'b1};
`else
    vecs[6] = '{0, 1'b1, 16'd17, 32'h77,       32'hDEADBEEF, 1'b0};
    vecs[7] = '{0, 1'b0, 16'd1,  32'h0,        32'h77,       1'b0};
    vecs[8] = '{0, 1'b0, 16'd17, 32'h0,        32'h77,       1'b0};
`endif
    vecs[9] = '{0, 1'b0, 16'd3,  32'h0,        32'hDEADBEEF, 1'b0};

    for (int i = 0; i < DEPTH; i++) begin
      mem_m[0][i] = 32'h0; mem_m[1][i] = 32'h0;
    end
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);

    // Reset values
    #12;
    chk("reset ack0", {31'b0, bus0.ack_o}, 32'h0);
    chk("reset err0", {31'b0, bus0.err_o}, 32'h0);
    chk("reset dat0", bus0.dat_o, 32'h0);
    chk("reset state0", {30'b0, st0}, {30'b0, ST_IDLE});
    chk("reset ack3", {31'b0, bus3.ack_o}, 32'h0);
    chk("reset err3", {31'b0, bus3.err_o}, 32'h0);
    chk("reset dat3", bus3.dat_o, 32'h0);
    chk("reset state3", {30'b0, st3}, {30'b0, ST_IDLE});
    #11 rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors from the table; the model follows along
    for (int i = 0; i < 10; i++) begin
      model_xfer(vecs[i].w, vecs[i].we, vecs[i].adr, vecs[i].d, e_err, e_dat);
      xfer(vecs[i].w, vecs[i].we, vecs[i].adr, vecs[i].d, vecs[i].exp_err, vecs[i].exp_dat,
           $sformatf("vec%0d", i));
    end

    // Back-to-back reads with the request held: one ack every 5 clocks
    drive(1, 1'b1, 1'b1, 1'b0, 16'd1, 32'h0);
    acks = 0; first_ack = 0; prev_ack = -10; consec = 0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (bus3.ack_o) begin
        acks++;
        if (acks == 1) first_ack = c;
        else chk("b2b gap", c - prev_ack, 5);
        if (c - prev_ack == 1) consec++;
        prev_ack = c;
        chk("b2b dat_o", bus3.dat_o, 32'h5);
      end
    end
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("b2b first ack", first_ack, 4);
    chk("b2b ack count", acks, 3);
    chk("b2b consecutive acks", consec, 0);
    model_xfer(1, 1'b0, 16'd1, 32'h0, e_err, e_dat);
    @(posedge clk); #1;

    // Abort: strobe dropped one clock into a 3-wait write
    drive(1, 1'b1, 1'b1, 1'b1, 16'd2, 32'hAA);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 1'b1, 16'd2, 32'hAA);
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus3.ack_o || bus3.err_o) acks++;
    end
    chk("abort no ack", acks, 0);
    chk("abort state idle", {30'b0, st3}, {30'b0, ST_IDLE});
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    model_and_xfer(1, 1'b0, 16'd2, 32'h0, "abort readback");
    chk("abort model addr2", mem_m[1][2], 32'h0);

    // Reset pulsed during the ACK cycle of a committed write
    model_xfer(0, 1'b1, 16'd5, 32'h12345678, e_err, e_dat);
    drive(0, 1'b1, 1'b1, 1'b1, 16'd5, 32'h12345678);
    @(posedge clk); #1;
    chk("rst-mid ack before", {31'b0, bus0.ack_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst-mid ack async drop", {31'b0, bus0.ack_o}, 32'h0);
    chk("rst-mid state", {30'b0, st0}, {30'b0, ST_IDLE});
    chk("rst-mid dat_o", bus0.dat_o, 32'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    #2 rst = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    @(posedge clk); #1;
    model_and_xfer(0, 1'b0, 16'd5, 32'h0, "rst-mid readback");

    // Random traffic: fill every word first so any read has a known answer
    for (int a = 0; a < DEPTH; a++) begin
      model_and_xfer(0, 1'b1, 16'(a), $urandom, $sformatf("fill0 a%0d", a));
      model_and_xfer(1, 1'b1, 16'(a), $urandom, $sformatf("fill3 a%0d", a));
    end
    for (int i = 0; i < 60; i++) begin
      int          w;
      bit          we;
      logic [15:0] adr;
      logic [31:0] d;
      w   = int'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      adr = 16'($urandom_range(0, 31));
      d   = $urandom;
      model_and_xfer(w, we, adr, d, $sformatf("rnd%0d w%0d we%0d a%0d", i, w, we, adr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_mem_slave.md
# wb_mem_slave

Wishbone classic-cycle slave with internal word memory and programmable wait-state insertion, sitting directly downstream of the AHB-to-Wishbone bridge. It consumes the bridge's `adr_o/dat_o/we_o/cyc_o/stb_o` and returns `ack_i/dat_i`. It serves as the bridge's synthesizable bus target and as the reference slave for bridge regression. Acknowledge is registered, and stall length is set at elaboration.

## Interface
- `DWIDTH`, 32: data bus width.
- `AWIDTH`, 16: address bus width (word address).
- `MEM_DEPTH`, 16: number of words; must be a power of two, at most 2^AWIDTH.
- `WAIT_STATES`, 0: cycles inserted between strobe capture and ack, 0..15.
- `clk_i` in 1: the block's only clock; all state changes on its rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `adr_i` in AWIDTH: word address.
- `dat_i` in DWIDTH: write data.
- `we_i` in 1: 1 = write, 0 = read.
- `cyc_i` in 1: bus cycle valid.
- `stb_i` in 1: transfer strobe.
- `dat_o` out DWIDTH: registered read data.
- `ack_o` out 1: registered acknowledge.
- `err_o` out 1: registered error; tied 0 unless `WB_MEM_SLAVE_ERR_EN` is defined.

## Operation
- **Reset values.** `ack_o`=0, `err_o`=0, `dat_o`=0, state=IDLE, wait counter=0. Memory contents are not reset.
- **Request.** A request is `cyc_i & stb_i`. Address, data and `we_i` are held stable by the master until ack.
- **IDLE.**
  - On a request with `WAIT_STATES`=0: go to ACK.
  - On a request with `WAIT_STATES`>0: go to WAIT and load the counter with `WAIT_STATES`-1.
- **WAIT.**
  - Counter decrements each cycle; when it is 0, go to ACK.
  - If the request drops (`cyc_i` or `stb_i` low), go to IDLE: abort, with no memory access and no ack.
- **Entry into ACK.** On the edge that enters ACK:
  - A write stores `dat_i` at `adr_i[log2(MEM_DEPTH)-1:0]`.
  - A read loads `dat_o` from the same index.
- **ACK.** `ack_o`=1 for exactly one cycle, then the block always returns to IDLE. A request still asserted in IDLE starts a new transfer, so `ack_o` is never high on two consecutive cycles.
- **`dat_o` hold.** `dat_o` holds its last read value until the next read; writes do not change it.
- **Address wrap (macro undefined).** Addresses ≥ MEM_DEPTH alias modulo MEM_DEPTH.
- **Request dropped in ACK.** The ack still completes; the master ignores it.
- **Reset mid-transfer.** `ack_o`/`err_o` drop immediately (asynchronously) and the FSM returns to IDLE. Any write already committed on an earlier edge is retained.

## Timing
- **Ack latency.**
  - The request is first sampled at edge E0.
  - `ack_o` is high in the cycle following edge E0+WAIT_STATES.
  - Latency from request to ack is WAIT_STATES+1 clocks.
- **Throughput.** Back-to-back transfers complete every WAIT_STATES+2 clocks.
- **Read data.** Read data is valid in the same cycle as `ack_o`.
- **No combinational paths.** There is no combinational path from any input to any output.

## Configuration
- **Macro `WB_MEM_SLAVE_ERR_EN`: range checking.**
- **Defined.**
  - A request with `adr_i` ≥ MEM_DEPTH raises `err_o` (not `ack_o`), with the same timing as ack.
  - The memory is not written.
  - `dat_o` is forced to 0 on an errored read.
- **Undefined.** `err_o` is constant 0 and addresses wrap modulo MEM_DEPTH.

## Structure
- **Shared package `wb_pkg`:**
  - default `DWIDTH`/`AWIDTH` constants;
  - FSM state encoding (IDLE=2'b00, WAIT=2'b01, ACK=2'b10);
  - `clog2` helper for the index width.
- **Sub-module `wb_mem_ram`:** synchronous-write/synchronous-read single-port array (`clk_i`, we, index, wdata, rdata), no reset. The FSM, wait counter and range check stay in `wb_mem_slave`.

## Test plan
- **Zero-wait write/read.** WAIT_STATES=0: write 0xDEADBEEF to addr 3, then read addr 3 → each ack one clock after the request; read `dat_o`=0xDEADBEEF.
- **Wait states.** WAIT_STATES=3: write 0x5 to addr 1 → `ack_o` exactly 4 clocks after the request; back-to-back reads repeat every 5 clocks.
- **Abort.** WAIT_STATES=3: drop `stb_i` after 1 clock of a write of 0xAA to addr 2 → no ack, addr 2 keeps its old value (0x0 after prior write 0x0).
- **Reset mid-transfer.** Pulse `rst_i` during the ACK cycle → `ack_o` falls within the same cycle; the subsequent read of that address returns the written value.
- **Out-of-range, macro defined.** Read addr 17 with MEM_DEPTH=16 → `err_o`=1 for one cycle, `ack_o`=0, `dat_o`=0.
- **Out-of-range, macro undefined.** Write 0x77 to addr 17 → reads back from addr 1.
